mux_nto1_scan: RTL and testbench

MUX_NTO1_SCAN -- requirements
Module: mux_nto1_scan

---
 rtl/mux_nto1_scan.sv | 129 ++++++++++++
 tb/tb_mux_nto1_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered N-to-1 channel multiplexer with manual select and
// automatic round-robin scan.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_bus     N packed channels, channel k = in_bus[k*WIDTH +: WIDTH]
//   sel        manual channel select; scan start channel on scan entry
//   mode       0 = manual select, 1 = round-robin scan
//   en         capture enable; low freezes data path, pointer and dwell count
//   out        registered selected data
//   out_ch     index of the channel currently held in out
//   out_valid  high for each cycle in which out was updated
//   scan_wrap  one-cycle pulse after the scan pointer wraps N-1 -> 0
module mux_nto1_scan #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_bus,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 en,
  output logic [WIDTH-1:0]     out,
  output logic [SEL_W-1:0]     out_ch,
  output logic                 out_valid,
  output logic                 scan_wrap
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0]  CntMax = CntW'(DWELL - 1);
  localparam logic [SEL_W-1:0] PtrMax = SEL_W'(N - 1);

  typedef enum logic [0:0] {StManual, StScan} state_e;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic               scan_entry;

  logic [WIDTH-1:0]   ch_arr [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign ch_arr[k] = in_bus[k*WIDTH +: WIDTH];
  end

  // A 0->1 mode change seen while disabled defers the scan load to the next
  // enabled edge; pend_q remembers that such a change is outstanding.
  assign scan_entry = mode && ((state_q == StManual) || pend_q);

  always_comb begin
    state_d  = mode ? StScan : StManual;
    pend_d   = pend_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    out_ch_d = out_ch_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;

    if (!en) begin
      if (mode && (state_q == StManual)) begin
        pend_d = 1'b1;
      end
    end else begin
      pend_d  = 1'b0;
      valid_d = 1'b1;
      if (!mode) begin
        out_d    = ch_arr[sel];
        out_ch_d = sel;
        ptr_d    = '0;
        cnt_d    = '0;
      end else if (scan_entry) begin
        // Entry cycle counts as the first dwell cycle on the start channel.
        ptr_d    = sel;
        cnt_d    = '0;
        out_d    = ch_arr[sel];
        out_ch_d = sel;
      end else begin
        if (cnt_q == CntMax) begin
          cnt_d  = '0;
          ptr_d  = ptr_q + SEL_W'(1);
          wrap_d = (ptr_q == PtrMax);
        end else begin
          cnt_d  = cnt_q + CntW'(1);
        end
        // Output follows the pointer as updated on this edge.
        out_d    = ch_arr[ptr_d];
        out_ch_d = ptr_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StManual;
      pend_q   <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      out_ch_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      out_ch_q <= out_ch_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = valid_q;
  assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Testbench for mux_nto1_scan (WIDTH=4, N=4, DWELL=2).
module tb_mux_nto1_scan;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int DW = 2;

  logic          clk;
  logic          rst;
  logic [N*W-1:0] in_bus;
  logic [SW-1:0] sel;
  logic          mode;
  logic          en;
  logic [W-1:0]  out;
  logic [SW-1:0] out_ch;
  logic          out_valid;
  logic          scan_wrap;

  mux_nto1_scan #(
    .WIDTH (W),
    .N     (N),
    .SEL_W (SW),
    .DWELL (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .scan_wrap (scan_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  out;
    logic [SW-1:0] ch;
    logic          valid;
    logic          wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a scan session is a start channel plus the number of
  // enabled cycles since entry; the channel is start + pos/DWELL (mod N).
  logic [W-1:0]  chans [N];
  logic [W-1:0]  m_out;
  logic [SW-1:0] m_ch;
  logic          m_valid;
  logic          m_wrap;
  logic          loaded;
  int            start;
  int            pos;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic e, input logic [SW-1:0] s);
    exp_t x;
    int   c;
    rst  = r;
    mode = m;
    en   = e;
    sel  = s;
    for (int k = 0; k < N; k++) in_bus[k*W +: W] = chans[k];
    if (r) begin
      m_out = '0; m_ch = '0; m_valid = 1'b0; m_wrap = 1'b0;
      loaded = 1'b0; pos = 0;
    end else if (!e) begin
      m_valid = 1'b0; m_wrap = 1'b0;
      if (!m) loaded = 1'b0;
    end else if (!m) begin
      m_out = chans[s]; m_ch = s; m_valid = 1'b1; m_wrap = 1'b0;
      loaded = 1'b0;
    end else if (!loaded) begin
      start = int'(s); pos = 0; loaded = 1'b1;
      m_out = chans[s]; m_ch = s; m_valid = 1'b1; m_wrap = 1'b0;
    end else begin
      pos++;
      c = (start + pos / DW) % N;
      m_ch = SW'(c); m_out = chans[c]; m_valid = 1'b1;
      m_wrap = ((pos % DW) == 0) && (c == 0);
    end
    x.out = m_out; x.ch = m_ch; x.valid = m_valid; x.wrap = m_wrap;
    @(posedge clk);
    #1;
    exp_q.push_back(x);
  endtask

  // Monitor: one registered response per cycle, compared on the falling edge.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("sb_valid", 32'(out_valid), 32'(x.valid));
      chk("sb_out",   32'(out),       32'(x.out));
      chk("sb_ch",    32'(out_ch),    32'(x.ch));
      chk("sb_wrap",  32'(scan_wrap), 32'(x.wrap));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   seq [9];
    logic mode_r;
    seq = '{1, 1, 2, 2, 3, 3, 0, 0, 1};
    for (int k = 0; k < N; k++) chans[k] = W'(k);
    loaded = 1'b0; pos = 0; start = 0;
    m_out = '0; m_ch = '0; m_valid = 1'b0; m_wrap = 1'b0;
    rst = 1'b1; mode = 1'b1; en = 1'b1; sel = '0; in_bus = '0;

    // Reset with en/mode high.
    step(1'b1, 1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_ch", 32'(out_ch), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_wrap", 32'(scan_wrap), 32'h0);

    // Manual select, then data change on the selected channel.
    step(1'b0, 1'b0, 1'b1, 2'd2);
    chk("man_out", 32'(out), 32'h2);
    chk("man_ch", 32'(out_ch), 32'h2);
    chk("man_valid", 32'(out_valid), 32'h1);
    chans[2] = 4'hC;
    step(1'b0, 1'b0, 1'b1, 2'd2);
    chk("man_upd", 32'(out), 32'hC);
    chans[2] = 4'h2;

    // Scan from channel 1.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 2'd1);
      chk("scan_seq_ch", 32'(out_ch), 32'(seq[i]));
      chk("scan_seq_wrap", 32'(scan_wrap), (i == 6) ? 32'h1 : 32'h0);
    end

    // Advance to the first cycle on channel 3, then freeze.
    for (int i = 0; i < 20 && !(m_ch == 2'd3 && (pos % DW) == 0); i++)
      step(1'b0, 1'b1, 1'b1, 2'd0);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, 2'd0);
      chk("frz_ch", 32'(out_ch), 32'h3);
      chk("frz_valid", 32'(out_valid), 32'h0);
    end
    step(1'b0, 1'b1, 1'b1, 2'd0);
    chk("unfrz_ch", 32'(out_ch), 32'h3);
    step(1'b0, 1'b1, 1'b1, 2'd0);
    chk("unfrz_wrap_ch", 32'(out_ch), 32'h0);
    chk("unfrz_wrap", 32'(scan_wrap), 32'h1);

    // Mode switch back to manual at channel 2, then rescan from 0.
    for (int i = 0; i < 20 && m_ch != 2'd2; i++) step(1'b0, 1'b1, 1'b1, 2'd3);
    step(1'b0, 1'b0, 1'b1, 2'd0);
    chk("sw_out", 32'(out), 32'h0);
    chk("sw_ch", 32'(out_ch), 32'h0);
    step(1'b0, 1'b1, 1'b1, 2'd0);
    step(1'b0, 1'b1, 1'b1, 2'd3);
    chk("rescan_dwell", 32'(out_ch), 32'h0);
    step(1'b0, 1'b1, 1'b1, 2'd3);
    chk("rescan_adv", 32'(out_ch), 32'h1);

    // Reset mid-scan, restart from sel=2.
    for (int i = 0; i < 20 && m_ch != 2'd3; i++) step(1'b0, 1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    step(1'b0, 1'b1, 1'b1, 2'd2);
    chk("restart_ch", 32'(out_ch), 32'h2);
    chk("restart_out", 32'(out), 32'h2);

    // Disabled mode change: scan load deferred to first enabled edge.
    step(1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b1, 1'b0, 2'd3);
    step(1'b0, 1'b1, 1'b1, 2'd3);
    chk("defer_ch", 32'(out_ch), 32'h3);

    // Randomized traffic.
    mode_r = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(9) == 0) mode_r = ~mode_r;
      if ($urandom_range(3) == 0) chans[$urandom_range(N-1)] = W'($urandom);
      step($urandom_range(59) == 0, mode_r, $urandom_range(4) != 0,
           SW'($urandom_range(N-1)));
    end

    step(1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
